// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: serial shift-add-3 binary-to-BCD converter, one bit per clock.
// Define BCD_SIGNED_EN to treat data as two's complement and report its sign on neg.
module bcd_seq_converter #(
    parameter int DATA_W = 30,
    parameter int DIGITS = 9
) (
    input  logic                Clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   data,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic                neg,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W);
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     dig_q;
    logic [CW-1:0]     cnt_q;
    logic              sticky_q;
    logic              neg_cap_q;

    logic [BW-1:0]     dig_adj;
    logic [BW-1:0]     dig_next;
    logic              carry_out;
    logic              sticky_next;
    logic [DATA_W-1:0] mag;
    logic              data_neg;
    logic              load;
    logic              step;
    logic              last;

`ifdef BCD_SIGNED_EN
    assign data_neg = data[DATA_W-1];
    // Negating -2^(DATA_W-1) wraps to itself, which is the right unsigned magnitude.
    assign mag      = data_neg ? -data : data;
`else
    assign data_neg = 1'b0;
    assign mag      = data;
`endif

    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Bit leaving the top digit means the value no longer fits in DIGITS digits.
    assign {carry_out, dig_next} = {dig_adj, shift_q[DATA_W-1]};
    assign sticky_next = sticky_q | carry_out;
    assign last        = (cnt_q == CW'(1));

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            dig_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            neg_cap_q <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            neg       <= 1'b0;
        end else if (load) begin
            shift_q   <= mag;
            dig_q     <= '0;
            cnt_q     <= CNT_LOAD;
            sticky_q  <= 1'b0;
            neg_cap_q <= data_neg;
        end else if (step) begin
            shift_q  <= shift_q << 1;
            dig_q    <= dig_next;
            cnt_q    <= cnt_q - CW'(1);
            sticky_q <= sticky_next;
            if (last) begin
                bcd <= sticky_next ? ALL_NINES : dig_next;
                ovf <= sticky_next;
                neg <= neg_cap_q;
            end
        end
    end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Sequential shift-add-3 (double-dabble) binary-to-BCD converter. It sits upstream of the 7-segment paging logic and downstream of the moving-average/FIR result.
- Accepts one binary word per start pulse.
- Produces DIGITS packed BCD digits, plus overflow and sign flags.
- Uses a start/busy/done handshake.
- Costs one clock per input bit, instead of a wide combinational divider chain.

Parameters:
DATA_W, 30, input word width in bits (>=4).
DIGITS, 9, number of BCD output digits (>=1).

Ports:
Clk    input   1           system clock, all state on rising edge
rst    input   1           asynchronous active-high reset
start  input   1           request conversion of data; sampled when busy=0
data   input   DATA_W      binary value to convert; sampled on accepted start edge only
busy   output  1           conversion in progress; start ignored while high
done   output  1           one-cycle pulse; bcd/ovf/neg valid and updated
ovf    output  1           value exceeded 10^DIGITS-1; bcd saturated
neg    output  1           input was negative (signed mode only)
bcd    output  4*DIGITS    packed result; digit 0 (ones) in bits [3:0]

Behaviour:
- Reset (async, any state): FSM to IDLE; busy=0, done=0, ovf=0, neg=0, bcd=0; shift/digit registers and counter cleared.
- FSM states: IDLE, CONV, DONE.
  - IDLE: busy=0, done=0. On start=1 at edge N: capture magnitude of data into the shift register, clear the digit accumulator and sticky ovf, load the counter with DATA_W, go to CONV.
  - CONV: busy=1. Each edge performs the following, then decrements the counter:
    - every 4-bit digit >=5 gets +3, all digits in parallel, combinational;
    - digits and shift register shift left 1, with the MSB of the shift register entering digit 0 bit 0;
    - the bit shifted out of the top digit's MSB ORs into sticky ovf.
  - CONV exit: at the edge where the counter reaches 0 (edge N+DATA_W), register the final digits into bcd, along with ovf and neg, and go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. The sampled view at edge N+DATA_W+1 is done=1.
    - start=1 in DONE is accepted exactly as in IDLE: go to CONV, with done low next cycle.
    - Otherwise go to IDLE.
- Latency: start sampled at edge N gives done observed high at edge N+DATA_W+1. Back-to-back throughput is one result per DATA_W+1 cycles.
- Overflow: if sticky ovf=1 at completion, bcd = all digits 4'h9 and ovf=1. ovf is held with bcd until the next done.
- Output hold: bcd, ovf and neg change only on the completion edge. They stay stable through IDLE and through the next conversion.
- start while busy=1: ignored; data is not re-sampled; the in-flight conversion is unaffected.
- Reset mid-CONV: the conversion is abandoned, no done pulse, outputs cleared.
- data=0: bcd=0, ovf=0, with full latency; there is no early exit.
- Digit values never exceed 9 in bcd.

Optional Feature:
Macro BCD_SIGNED_EN.
- Defined:
  - data is two's complement; neg=data[DATA_W-1] is captured at start.
  - The magnitude (−data if negative) is converted as a DATA_W-bit unsigned value, so −2^(DATA_W-1) converts correctly.
  - neg is registered with bcd at completion.
- Undefined:
  - data is unsigned; neg is tied 0 and no negation logic is generated.
- Latency is identical in both modes.

Test Plan:
1. Reset, then start with data=0 at edge N → busy=1 for edges N+1..N+30; done=1 only at edge N+31; bcd=36'h000000000; ovf=0.
2. data=999999999 → bcd=36'h999999999, ovf=0. Then data=1000000000 → ovf=1, bcd=36'h999999999.
3. data=12345 accepted; pulse start with data=777 at N+5 → the second start is ignored; result bcd=36'h000012345; exactly one done.
4. start held high continuously, data=42 then 43 → results 42 and 43 on consecutive done pulses 31 cycles apart, with done low between them. Restart from DONE is verified.
5. Assert rst at edge N+10 of a conversion → busy, done, ovf and bcd are 0 immediately (asynchronous); no done appears afterwards. The next start converts normally.
6. With BCD_SIGNED_EN defined:
   - data=−128 (30'h3FFFFF80) → neg=1, bcd=36'h000000128.
   - data=−2^29 → neg=1, bcd=36'h536870912.
   - data=+5 → neg=0.
